// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the two-input gate BIST controller.
// Exports the FSM state enum and the standard gate truth tables.
package gate_bist_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      CHECK  = 2'd2,
      DONE   = 2'd3
   } state_t;

   // Bit i is the expected gate output for input index {a,b} = i.
   localparam logic [3:0] TRUTH_NAND = 4'b0111;
   localparam logic [3:0] TRUTH_AND  = 4'b1000;

   localparam logic [1:0] LAST_VEC = 2'd3;
   localparam logic [2:0] ERR_MAX  = 3'd4;

endpackage

// File: rtl/gate_bist_ctrl_if.sv
// Signal bundle between the BIST controller and its gate under test.
// master: controller view; slave: gate/host view.
interface gate_bist_ctrl_if;

   logic       start;
   logic       gate_a;
   logic       gate_b;
   logic       gate_y;
   logic       busy;
   logic       done;
   logic       pass;
   logic [2:0] err_cnt;
   logic [1:0] fail_vec;

   modport master (
      input  start, gate_y,
      output gate_a, gate_b, busy, done,
      output pass, err_cnt, fail_vec
   );

   modport slave (
      output start, gate_y,
      input  gate_a, gate_b, busy, done,
      input  pass, err_cnt, fail_vec
   );

endinterface

// File: rtl/gate_bist_ctrl.sv
// Exhaustive 4-vector self-test of one two-input gate.
// Ports: clk, rst_n (async low), start; gate_a/gate_b/gate_y to the
// gate; busy, done (pulse), pass, err_cnt, fail_vec results.
module gate_bist_ctrl
   import gate_bist_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter logic [3:0]  TRUTH         = TRUTH_NAND
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       gate_a,
   output logic       gate_b,
   input  logic       gate_y,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_cnt,
   output logic [1:0] fail_vec
);

   localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

   state_t     state_q, state_d;
   logic [1:0] vec_q, vec_d;
   logic [3:0] cnt_q, cnt_d;
   logic [1:0] ab_q, ab_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       pass_q, pass_d;
   logic [2:0] err_q, err_d;
   logic [1:0] fail_q, fail_d;
   logic       mis;

   // Case inequality so an undriven or X output counts as a miss.
   assign mis = (gate_y !== TRUTH[vec_q]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:   if (start) state_d = SETTLE;
         SETTLE: if (cnt_q <= 4'd1) state_d = CHECK;
         CHECK:  state_d = (vec_q == LAST_VEC) ? DONE : SETTLE;
         DONE:   state_d = IDLE;
      endcase
   end

   always_comb begin
      vec_d  = vec_q;
      cnt_d  = cnt_q;
      err_d  = err_q;
      fail_d = fail_q;
      pass_d = pass_q;
      done_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               vec_d  = 2'd0;
               cnt_d  = SETTLE_LD;
               err_d  = 3'd0;
               fail_d = 2'd0;
               pass_d = 1'b0;
            end
         end
         SETTLE: cnt_d = cnt_q - 4'd1;
         CHECK: begin
            if (mis) begin
               err_d = (err_q == ERR_MAX) ? ERR_MAX : err_q + 3'd1;
               if (err_q == 3'd0) fail_d = vec_q;
            end
            if (vec_q != LAST_VEC) begin
               vec_d = vec_q + 2'd1;
               cnt_d = SETTLE_LD;
            end else begin
               done_d = 1'b1;
               pass_d = (err_d == 3'd0);
            end
         end
         DONE: begin
         end
      endcase
      busy_d = (state_d == SETTLE) || (state_d == CHECK);
      ab_d   = busy_d ? vec_d : 2'b00;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec_q  <= 2'd0;
         cnt_q  <= 4'd0;
         ab_q   <= 2'b00;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         pass_q <= 1'b0;
         err_q  <= 3'd0;
         fail_q <= 2'd0;
      end else begin
         vec_q  <= vec_d;
         cnt_q  <= cnt_d;
         ab_q   <= ab_d;
         busy_q <= busy_d;
         done_q <= done_d;
         pass_q <= pass_d;
         err_q  <= err_d;
         fail_q <= fail_d;
      end
   end

   assign gate_a   = ab_q[1];
   assign gate_b   = ab_q[0];
   assign busy     = busy_q;
   assign done     = done_q;
   assign pass     = pass_q;
   assign err_cnt  = err_q;
   assign fail_vec = fail_q;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Bench for gate_bist_ctrl: three instances (NAND/S=2, AND/S=2,
// NAND/S=1) driven by modelled gates, checked against a truth model.
module tb_gate_bist_ctrl;
   import gate_bist_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [3:0] gfun [3];
   int         n_vec = 0;
   int         n_bad = 0;

   gate_bist_ctrl_if bus [3] ();

   logic [1:0] o_ab   [3];
   logic       o_busy [3];
   logic       o_done [3];
   logic       o_pass [3];
   logic [2:0] o_err  [3];
   logic [1:0] o_fail [3];

   always #5 clk = ~clk;

   for (genvar i = 0; i < 3; i++) begin : g_bus
      assign bus[i].start  = start;
      assign bus[i].gate_y = gfun[i][{bus[i].gate_a, bus[i].gate_b}];
      assign o_ab[i]   = {bus[i].gate_a, bus[i].gate_b};
      assign o_busy[i] = bus[i].busy;
      assign o_done[i] = bus[i].done;
      assign o_pass[i] = bus[i].pass;
      assign o_err[i]  = bus[i].err_cnt;
      assign o_fail[i] = bus[i].fail_vec;
   end

   gate_bist_ctrl u0 (
      .clk(clk), .rst_n(rst_n), .start(bus[0].start),
      .gate_a(bus[0].gate_a), .gate_b(bus[0].gate_b),
      .gate_y(bus[0].gate_y), .busy(bus[0].busy),
      .done(bus[0].done), .pass(bus[0].pass),
      .err_cnt(bus[0].err_cnt), .fail_vec(bus[0].fail_vec)
   );

   gate_bist_ctrl #(.TRUTH(TRUTH_AND)) u1 (
      .clk(clk), .rst_n(rst_n), .start(bus[1].start),
      .gate_a(bus[1].gate_a), .gate_b(bus[1].gate_b),
      .gate_y(bus[1].gate_y), .busy(bus[1].busy),
      .done(bus[1].done), .pass(bus[1].pass),
      .err_cnt(bus[1].err_cnt), .fail_vec(bus[1].fail_vec)
   );

   gate_bist_ctrl #(.SETTLE_CYCLES(1)) u2 (
      .clk(clk), .rst_n(rst_n), .start(bus[2].start),
      .gate_a(bus[2].gate_a), .gate_b(bus[2].gate_b),
      .gate_y(bus[2].gate_y), .busy(bus[2].busy),
      .done(bus[2].done), .pass(bus[2].pass),
      .err_cnt(bus[2].err_cnt), .fail_vec(bus[2].fail_vec)
   );

   task automatic check(input string tag,
                        input logic [7:0] got,
                        input logic [7:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", tag, got, exp);
      end
   endtask

   function automatic int ref_err(input logic [3:0] g,
                                  input logic [3:0] t);
      int n = 0;
      for (int i = 0; i < 4; i++)
         if (g[i] != t[i]) n++;
      return n;
   endfunction

   function automatic int ref_fail(input logic [3:0] g,
                                   input logic [3:0] t);
      for (int i = 0; i < 4; i++)
         if (g[i] != t[i]) return i;
      return 0;
   endfunction

   task automatic check_zero(input int d);
      check($sformatf("u%0d.rst_ab", d), 8'(o_ab[d]), 8'd0);
      check($sformatf("u%0d.rst_busy", d), 8'(o_busy[d]), 8'd0);
      check($sformatf("u%0d.rst_done", d), 8'(o_done[d]), 8'd0);
      check($sformatf("u%0d.rst_pass", d), 8'(o_pass[d]), 8'd0);
      check($sformatf("u%0d.rst_err", d), 8'(o_err[d]), 8'd0);
      check($sformatf("u%0d.rst_fail", d), 8'(o_fail[d]), 8'd0);
   endtask

   // c = cycles since the edge that accepted start.
   task automatic check_dut(input int d, input int c);
      int         p;
      logic [3:0] t;
      int         ne;
      p  = (d == 2) ? 2 : 3;
      t  = (d == 1) ? TRUTH_AND : TRUTH_NAND;
      ne = ref_err(gfun[d], t);
      if (c < 4 * p) begin
         check($sformatf("u%0d.ab@%0d", d, c), 8'(o_ab[d]), 8'(c / p));
         check($sformatf("u%0d.busy@%0d", d, c), 8'(o_busy[d]), 8'd1);
         check($sformatf("u%0d.done@%0d", d, c), 8'(o_done[d]), 8'd0);
      end else begin
         check($sformatf("u%0d.ab@%0d", d, c), 8'(o_ab[d]), 8'd0);
         check($sformatf("u%0d.busy@%0d", d, c), 8'(o_busy[d]), 8'd0);
         check($sformatf("u%0d.done@%0d", d, c), 8'(o_done[d]),
               8'(c == 4 * p));
         check($sformatf("u%0d.pass", d), 8'(o_pass[d]), 8'(ne == 0));
         check($sformatf("u%0d.err", d), 8'(o_err[d]), 8'(ne));
         check($sformatf("u%0d.fail", d), 8'(o_fail[d]),
               8'(ref_fail(gfun[d], t)));
      end
   endtask

   // rp: cycle at which start is re-raised (-1 none);
   // ab: cycle at which reset hits mid-run (-1 none).
   task automatic run(input logic [3:0] g0, input logic [3:0] g1,
                      input logic [3:0] g2, input int rp,
                      input int ab);
      gfun[0] = g0;
      gfun[1] = g1;
      gfun[2] = g2;
      start   = 1'b1;
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         if (c == ab) begin
            #2 rst_n = 1'b0;
            #1;
            for (int d = 0; d < 3; d++) check_zero(d);
            repeat (3) begin
               @(negedge clk);
               for (int d = 0; d < 3; d++) begin
                  check($sformatf("u%0d.ab_done", d), 8'(o_done[d]), 8'd0);
                  check($sformatf("u%0d.ab_busy", d), 8'(o_busy[d]), 8'd0);
               end
            end
            rst_n = 1'b1;
            @(negedge clk);
            return;
         end
         for (int d = 0; d < 3; d++) check_dut(d, c);
         start = (c == rp);
      end
      start = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      for (int d = 0; d < 3; d++) gfun[d] = TRUTH_NAND;
      repeat (2) @(negedge clk);
      for (int d = 0; d < 3; d++) check_zero(d);
      rst_n = 1'b1;
      @(negedge clk);

      run(TRUTH_NAND, TRUTH_NAND, TRUTH_NAND, -1, -1);
      run(4'b1111, TRUTH_NAND, TRUTH_NAND, -1, -1);
      run(4'b0000, 4'b1111, 4'b0000, -1, -1);
      run(TRUTH_NAND, TRUTH_AND, TRUTH_NAND, 3, -1);
      run(TRUTH_NAND, TRUTH_NAND, TRUTH_NAND, -1, 7);
      run(TRUTH_NAND, TRUTH_NAND, TRUTH_NAND, -1, -1);

      repeat (10) begin
         run(4'($urandom), 4'($urandom), 4'($urandom), -1, -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/gate_bist_ctrl.md
GATE_BIST_CTRL -- requirements
Module: gate_bist_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, meaning cycles each vector is held before sampling (legal 1..15).
REQ-002 SHALL have parameter TRUTH, 4 bits, default 4'b0111, meaning the expected gate output for input index {a,b}: bit i is the expected y for {a,b}=i (default is NAND).
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state rising-edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1 bit: request a test run, sampled only in IDLE.
REQ-006 SHALL have port gate_a, output, 1 bit: drives gate-under-test input a.
REQ-007 SHALL have port gate_b, output, 1 bit: drives gate-under-test input b.
REQ-008 SHALL have port gate_y, input, 1 bit: gate-under-test output.
REQ-009 SHALL have port busy, output, 1 bit: high while a run is in progress.
REQ-010 SHALL have port done, output, 1 bit: single-cycle end-of-run pulse.
REQ-011 SHALL have port pass, output, 1 bit: result of the last completed run, 1 when err_cnt==0.
REQ-012 SHALL have port err_cnt, output, 3 bits: mismatching vectors in the last run, 0..4.
REQ-013 SHALL have port fail_vec, output, 2 bits: index {a,b} of the first mismatching vector; 0 when none.

Function
REQ-014 SHALL implement FSM states IDLE, SETTLE, CHECK, DONE; all state is registered and gate_a/gate_b are driven from registers.
REQ-015 SHALL, in IDLE with start=1 at edge k, go to SETTLE, set vec=0, clear err_cnt/fail_vec/pass, and load the settle counter with SETTLE_CYCLES.
REQ-016 SHALL drive {gate_a,gate_b}=vec in SETTLE and CHECK; vector v is applied from edge k+v*(SETTLE_CYCLES+1).
REQ-017 SHALL stay in SETTLE for exactly SETTLE_CYCLES cycles, then enter CHECK for exactly one cycle.
REQ-018 SHALL compare gate_y against TRUTH[vec] at the edge leaving CHECK; any inequality (X/Z included) is a mismatch.
REQ-019 SHALL, on a mismatch, increment err_cnt (saturating at 4), and load fail_vec with vec only if this is the first mismatch of the run.
REQ-020 SHALL, leaving CHECK with vec<3, increment vec and return to SETTLE with the counter reloaded; with vec==3, go to DONE.
REQ-021 SHALL hold busy=1 in SETTLE and CHECK and busy=0 in IDLE and DONE.
REQ-022 SHALL assert done=1 for exactly the one DONE cycle, beginning at edge k+4*(SETTLE_CYCLES+1) (k+12 at the default), then return to IDLE.
REQ-023 SHALL update pass on entry to DONE and hold pass, err_cnt and fail_vec until the next accepted start.
REQ-024 SHALL ignore start in SETTLE, CHECK and DONE, so start held high restarts only from IDLE.
REQ-025 SHALL drive gate_a=gate_b=0 in IDLE and DONE.

Reset
REQ-026 SHALL, while rst_n=0 and independent of clk, force: state IDLE, vec 0, counter 0, gate_a 0, gate_b 0, busy 0, done 0, pass 0, err_cnt 0, fail_vec 0.
REQ-027 SHALL, on reset mid-run, abandon the run with no done pulse; the first start after rst_n rises runs a complete fresh test.

Structure
REQ-028 SHALL take the FSM state enum and the constants TRUTH_NAND=4'b0111 and TRUTH_AND=4'b1000 from a shared package gate_bist_pkg.
REQ-029 SHALL be a single module with no sub-modules; the settle counter and vector counter are inline registers.

Verification
REQ-030 SHALL cover: correct NAND model on gate_y, start pulse at edge k -> vectors 00,01,10,11 applied; done at k+12; pass=1, err_cnt=0, fail_vec=0.
REQ-031 SHALL cover: gate_y stuck at 1 -> err_cnt=1, fail_vec=3, pass=0.
REQ-032 SHALL cover: gate_y stuck at 0 -> err_cnt=3, fail_vec=0, pass=0.
REQ-033 SHALL cover: TRUTH=TRUTH_AND with a NAND model -> err_cnt=4, fail_vec=0, pass=0.
REQ-034 SHALL cover: start re-pulsed during vector 1 -> ignored, single done at k+12; rst_n low during vector 2 -> all outputs 0 immediately, no done; a new start then gives a full passing run.
REQ-035 SHALL cover: SETTLE_CYCLES=1 with a NAND model -> done at k+8, pass=1.
